// File: rtl/nn_pkg.sv
// Shared definitions for the layer sequencer and the neuron datapath:
// the sequencer state type and the width helpers that every layer derives
// its accumulator and rescale geometry from.
package nn_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAC   = 3'd1,
        BIAS  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Extra accumulator bits needed to sum n_in products without overflow.
    function automatic int growth_w(input int n_in);
        return $clog2(n_in) + 1;
    endfunction

    // Width of the accumulator and of the biased sum z.
    function automatic int acc_w(input int res, input int n_in);
        return 2 * res + growth_w(n_in) + 1;
    endfunction

    // Right shift applied to |z| to bring it back to res bits.
    function automatic int shift_w(input int res, input int n_in);
        return res + growth_w(n_in) + 1;
    endfunction

    // Address width for a memory of 'depth' entries; never below one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Control handshake plus the four memory ports the layer sequencer drives:
// input feature buffer, weight ROM, bias ROM and the output buffer.
interface layer_sequencer_if
    import nn_pkg::*;
#(
    parameter int N_IN  = 16,
    parameter int N_OUT = 10,
    parameter int RES   = 8
);

    localparam int IW = addr_w(N_IN);
    localparam int WA = addr_w(N_IN * N_OUT);
    localparam int OW = addr_w(N_OUT);

    // Layer control
    logic                  start;
    logic                  busy;
    logic                  done;

    // Input feature buffer (synchronous read, one cycle latency)
    logic [IW-1:0]         in_addr;
    logic signed [RES-1:0] in_data;

    // Weight ROM (synchronous read), address n*N_IN+k
    logic [WA-1:0]         w_addr;
    logic signed [RES-1:0] w_data;

    // Bias ROM (synchronous read), address n
    logic [OW-1:0]         b_addr;
    logic signed [RES-1:0] b_data;

    // Output buffer write port
    logic                  out_we;
    logic [OW-1:0]         out_addr;
    logic signed [RES-1:0] out_data;

    // Sequencer side
    modport master (
        input  start,
        input  in_data,
        input  w_data,
        input  b_data,
        output busy,
        output done,
        output in_addr,
        output w_addr,
        output b_addr,
        output out_we,
        output out_addr,
        output out_data
    );

    // Controller and memory side
    modport slave (
        output start,
        output in_data,
        output w_data,
        output b_data,
        input  busy,
        input  done,
        input  in_addr,
        input  w_addr,
        input  b_addr,
        input  out_we,
        input  out_addr,
        input  out_data
    );

endinterface

// File: rtl/nn_rescale.sv
// Sign-magnitude rescale of a biased neuron sum: the magnitude is shifted
// right and the sign reapplied, so results round toward zero rather than
// toward minus infinity as a plain arithmetic shift would.
module nn_rescale #(
    parameter int RES   = 8,
    parameter int ACC_W = 20,
    parameter int SHIFT = 12
) (
    input  logic signed [ACC_W-1:0] z,
    output logic signed [RES-1:0]   y
);

    logic [ACC_W-1:0] mag;
    logic [RES-1:0]   res;
    logic             unused_low_bits;

    // Magnitude, shift, truncate to RES bits, restore sign.
    always_comb begin
        mag = z[ACC_W-1] ? ACC_W'(-z) : ACC_W'(z);
        res = mag[SHIFT +: RES];
        y   = z[ACC_W-1] ? -res : res;
    end

    // Fractional bits below the shift point are discarded by design.
    assign unused_low_bits = ^mag[SHIFT-1:0];

endmodule

// File: rtl/layer_sequencer.sv
// Runs one serial multiply-accumulate datapath over every neuron of a
// fully-connected layer: N_IN+1 MAC cycles, one bias/rescale cycle and one
// write cycle per neuron, then a single done pulse.
module layer_sequencer
    import nn_pkg::*;
#(
    parameter int N_IN  = 16,
    parameter int N_OUT = 10,
    parameter int RES   = 8
) (
    input  logic               clk,
    input  logic               reset,
    layer_sequencer_if.master  bus
);

    localparam int ACC_W = acc_w(RES, N_IN);
    localparam int SHIFT = shift_w(RES, N_IN);
    localparam int IW    = addr_w(N_IN);
    localparam int WA    = addr_w(N_IN * N_OUT);
    localparam int OW    = addr_w(N_OUT);
    // k runs 0..N_IN inclusive: the extra value covers the drain cycle in
    // which the last product (issued at k=N_IN-1) arrives.
    localparam int KW    = $clog2(N_IN + 1);

    localparam logic [KW-1:0] K_LAST = KW'(N_IN);
    localparam logic [OW-1:0] N_LAST = OW'(N_OUT - 1);
    localparam logic [WA-1:0] W_STEP = WA'(N_IN);

    state_t                   state_reg, state_next;
    logic [OW-1:0]            n_reg, n_next;
    logic [KW-1:0]            k_reg, k_next;
    logic [WA-1:0]            w_base_reg, w_base_next;
    logic signed [ACC_W-1:0]  acc_reg, acc_next;
    logic signed [RES-1:0]    out_data_reg, out_data_next;

    logic signed [2*RES-1:0]  prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  z;
    logic signed [RES-1:0]    rescaled;
    logic                     issue;

    // Full-precision signed product; -2^(RES-1) squared still fits 2*RES bits.
    assign prod     = $signed({{RES{bus.in_data[RES-1]}}, bus.in_data}) *
                      $signed({{RES{bus.w_data[RES-1]}}, bus.w_data});
    assign prod_ext = {{(ACC_W-2*RES){prod[2*RES-1]}}, prod};
    assign bias_ext = {{(ACC_W-RES){bus.b_data[RES-1]}}, bus.b_data};

    // Bias is added unscaled, as a plain integer, before the rescale.
    assign z = acc_reg + bias_ext;

    nn_rescale #(
        .RES   (RES),
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_rescale (
        .z (z),
        .y (rescaled)
    );

    // Address issue happens in MAC cycles 0..N_IN-1; the last MAC cycle only drains.
    assign issue = (state_reg == MAC) && (k_reg != K_LAST);

    // State and datapath registers; reset aborts a run immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            n_reg        <= '0;
            k_reg        <= '0;
            w_base_reg   <= '0;
            acc_reg      <= '0;
            out_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            n_reg        <= n_next;
            k_reg        <= k_next;
            w_base_reg   <= w_base_next;
            acc_reg      <= acc_next;
            out_data_reg <= out_data_next;
        end
    end

    // Next-state and datapath update for the per-neuron MAC/BIAS/WRITE loop.
    always_comb begin
        state_next    = state_reg;
        n_next        = n_reg;
        k_next        = k_reg;
        w_base_next   = w_base_reg;
        acc_next      = acc_reg;
        out_data_next = out_data_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next  = MAC;
                    n_next      = '0;
                    k_next      = '0;
                    w_base_next = '0;
                    acc_next    = '0;
                end
            end

            MAC: begin
                // Data for the address issued at k-1 is on the bus now.
                if (k_reg != '0) begin
                    acc_next = acc_reg + prod_ext;
                end
                if (k_reg == K_LAST) begin
                    state_next = BIAS;
                end else begin
                    k_next = k_reg + KW'(1);
                end
            end

            BIAS: begin
                out_data_next = rescaled;
                state_next    = WRITE;
            end

            WRITE: begin
                if (n_reg == N_LAST) begin
                    state_next = DONE;
                end else begin
                    state_next  = MAC;
                    n_next      = n_reg + OW'(1);
                    k_next      = '0;
                    w_base_next = w_base_reg + W_STEP;
                    acc_next    = '0;
                end
            end

            DONE: begin
                // A start seen here is dropped; it must be re-issued in IDLE.
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Status, strobes and addresses decoded from the registered state.
    assign bus.busy     = (state_reg != IDLE);
    assign bus.done     = (state_reg == DONE);
    assign bus.out_we   = (state_reg == WRITE);
    assign bus.out_addr = n_reg;
    assign bus.out_data = out_data_reg;
    assign bus.b_addr   = n_reg;
    assign bus.in_addr  = issue ? k_reg[IW-1:0] : '0;
    assign bus.w_addr   = issue ? (w_base_reg + WA'(k_reg[IW-1:0])) : '0;

endmodule
